// File: rtl/alu_operand_stage_pkg.sv
// Shared widths, ALU opcode encodings and forwarding-source encodings
// for the operand stage that feeds the 16-bit ALU.
package alu_operand_stage_pkg;

    localparam int DATA_W  = 16;
    localparam int RADDR_W = 2;
    localparam int OP_W    = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'h0;
    localparam logic [OP_W-1:0] ALU_ADC = 4'h1;
    localparam logic [OP_W-1:0] ALU_SUB = 4'h2;
    localparam logic [OP_W-1:0] ALU_SBC = 4'h3;
    localparam logic [OP_W-1:0] ALU_AND = 4'h4;
    localparam logic [OP_W-1:0] ALU_OR  = 4'h5;
    localparam logic [OP_W-1:0] ALU_XOR = 4'h6;
    localparam logic [OP_W-1:0] ALU_LHI = 4'h7;

    typedef enum logic [1:0] {
        FWD_SRC_REG = 2'd0,
        FWD_SRC_EX  = 2'd1,
        FWD_SRC_WB  = 2'd2
    } fwdSrc_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Picks one source operand: the retiring ALU result beats the writeback
// stage, which beats the register-file read data.
module operand_forward_mux
    import alu_operand_stage_pkg::*;
(
    input  logic [RADDR_W-1:0] src_addr_i,
    input  logic               ex_valid_i,
    input  logic [RADDR_W-1:0] ex_addr_i,
    input  logic [DATA_W-1:0]  ex_data_i,
    input  logic               wb_valid_i,
    input  logic [RADDR_W-1:0] wb_addr_i,
    input  logic [DATA_W-1:0]  wb_data_i,
    input  logic [DATA_W-1:0]  reg_data_i,
    output logic [DATA_W-1:0]  data_o
);

    fwdSrc_e fwdSel;

    always_comb begin
        fwdSel = FWD_SRC_REG;
        if (ex_valid_i && (ex_addr_i == src_addr_i)) begin
            fwdSel = FWD_SRC_EX;
        end else if (wb_valid_i && (wb_addr_i == src_addr_i)) begin
            fwdSel = FWD_SRC_WB;
        end
    end

    always_comb begin
        data_o = reg_data_i;
        case (fwdSel)
            FWD_SRC_EX: data_o = ex_data_i;
            FWD_SRC_WB: data_o = wb_data_i;
            default:    data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand stage in front of the ALU: one-deep holding register
// with valid/ready handshake, RAW forwarding and the architectural carry flag.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [RADDR_W-1:0] in_rs_addr,
    input  logic [RADDR_W-1:0] in_rt_addr,
    input  logic [DATA_W-1:0]  in_rs_data,
    input  logic [DATA_W-1:0]  in_rt_data,
    input  logic [DATA_W-1:0]  in_imm,
    input  logic               in_use_imm,
    input  logic               in_use_carry,
    input  logic               in_set_carry,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_wr_en,
    input  logic               flush,
    input  logic               wb_valid,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  alu_input1,
    output logic [DATA_W-1:0]  alu_input2,
    output logic               alu_cin,
    output logic [OP_W-1:0]    alu_op,
    output logic [RADDR_W-1:0] out_rd_addr,
    output logic               out_wr_en,
    output logic               out_set_carry,
    output logic               carry_flag
);

    logic               outValid_q,    outValid_d;
    logic [DATA_W-1:0]  input1_q,      input1_d;
    logic [DATA_W-1:0]  input2_q,      input2_d;
    logic               cin_q,         cin_d;
    logic [OP_W-1:0]    op_q,          op_d;
    logic [RADDR_W-1:0] rdAddr_q,      rdAddr_d;
    logic               wrEn_q,        wrEn_d;
    logic               setCarry_q,    setCarry_d;
    logic               carryFlag_q,   carryFlag_d;

    logic               accept;
    logic               retire;
    logic               exFwdValid;
    logic               liveCarry;
    logic [DATA_W-1:0]  rsFwd;
    logic [DATA_W-1:0]  rtFwd;

    assign in_ready   = ~outValid_q | out_ready;
    assign accept     = in_valid & in_ready & ~flush;
    assign retire     = outValid_q & out_ready & ~flush;
    assign exFwdValid = retire & wrEn_q;
    // A retiring carry-setter hands its Cout straight to the incoming ADC/SBC.
    assign liveCarry  = (retire & setCarry_q) ? alu_cout : carryFlag_q;

    operand_forward_mux rsMux (
        .src_addr_i (in_rs_addr),
        .ex_valid_i (exFwdValid),
        .ex_addr_i  (rdAddr_q),
        .ex_data_i  (alu_result),
        .wb_valid_i (wb_valid),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .reg_data_i (in_rs_data),
        .data_o     (rsFwd)
    );

    operand_forward_mux rtMux (
        .src_addr_i (in_rt_addr),
        .ex_valid_i (exFwdValid),
        .ex_addr_i  (rdAddr_q),
        .ex_data_i  (alu_result),
        .wb_valid_i (wb_valid),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .reg_data_i (in_rt_data),
        .data_o     (rtFwd)
    );

    always_comb begin
        outValid_d  = outValid_q;
        input1_d    = input1_q;
        input2_d    = input2_q;
        cin_d       = cin_q;
        op_d        = op_q;
        rdAddr_d    = rdAddr_q;
        wrEn_d      = wrEn_q;
        setCarry_d  = setCarry_q;
        carryFlag_d = carryFlag_q;

        if (accept) begin
            outValid_d = 1'b1;
            input1_d   = rsFwd;
            input2_d   = in_use_imm ? in_imm : rtFwd;
            cin_d      = in_use_carry & liveCarry;
            op_d       = in_op;
            rdAddr_d   = in_rd_addr;
            wrEn_d     = in_wr_en;
            setCarry_d = in_set_carry;
        end else if (retire || flush) begin
            outValid_d = 1'b0;
        end

        if (retire && setCarry_q) begin
            carryFlag_d = alu_cout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_q  <= 1'b0;
            input1_q    <= '0;
            input2_q    <= '0;
            cin_q       <= 1'b0;
            op_q        <= '0;
            rdAddr_q    <= '0;
            wrEn_q      <= 1'b0;
            setCarry_q  <= 1'b0;
            carryFlag_q <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            input1_q    <= input1_d;
            input2_q    <= input2_d;
            cin_q       <= cin_d;
            op_q        <= op_d;
            rdAddr_q    <= rdAddr_d;
            wrEn_q      <= wrEn_d;
            setCarry_q  <= setCarry_d;
            carryFlag_q <= carryFlag_d;
        end
    end

    assign out_valid     = outValid_q;
    assign alu_input1    = input1_q;
    assign alu_input2    = input2_q;
    assign alu_cin       = cin_q;
    assign alu_op        = op_q;
    assign out_rd_addr   = rdAddr_q;
    assign out_wr_en     = wrEn_q;
    assign out_set_carry = setCarry_q;
    assign carry_flag    = carryFlag_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage; the bench itself plays the ALU by
// driving alu_result/alu_cout with hand-computed values.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_op;
    logic [RADDR_W-1:0] in_rs_addr, in_rt_addr;
    logic [DATA_W-1:0]  in_rs_data, in_rt_data, in_imm;
    logic               in_use_imm, in_use_carry, in_set_carry;
    logic [RADDR_W-1:0] in_rd_addr;
    logic               in_wr_en;
    logic               flush;
    logic               wb_valid;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_cout;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  alu_input1, alu_input2;
    logic               alu_cin;
    logic [OP_W-1:0]    alu_op;
    logic [RADDR_W-1:0] out_rd_addr;
    logic               out_wr_en, out_set_carry, carry_flag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_rs_addr    (in_rs_addr),
        .in_rt_addr    (in_rt_addr),
        .in_rs_data    (in_rs_data),
        .in_rt_data    (in_rt_data),
        .in_imm        (in_imm),
        .in_use_imm    (in_use_imm),
        .in_use_carry  (in_use_carry),
        .in_set_carry  (in_set_carry),
        .in_rd_addr    (in_rd_addr),
        .in_wr_en      (in_wr_en),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .alu_result    (alu_result),
        .alu_cout      (alu_cout),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_input1    (alu_input1),
        .alu_input2    (alu_input2),
        .alu_cin       (alu_cin),
        .alu_op        (alu_op),
        .out_rd_addr   (out_rd_addr),
        .out_wr_en     (out_wr_en),
        .out_set_carry (out_set_carry),
        .carry_flag    (carry_flag)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic [OP_W-1:0]    op,
        input logic [RADDR_W-1:0] rs,
        input logic [DATA_W-1:0]  rsData,
        input logic [RADDR_W-1:0] rt,
        input logic [DATA_W-1:0]  rtData,
        input logic               useImm,
        input logic [DATA_W-1:0]  imm,
        input logic               useCarry,
        input logic               setCarry,
        input logic [RADDR_W-1:0] rd,
        input logic               wrEn
    );
        in_valid     = 1'b1;
        in_op        = op;
        in_rs_addr   = rs;
        in_rs_data   = rsData;
        in_rt_addr   = rt;
        in_rt_data   = rtData;
        in_use_imm   = useImm;
        in_imm       = imm;
        in_use_carry = useCarry;
        in_set_carry = setCarry;
        in_rd_addr   = rd;
        in_wr_en     = wrEn;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b1;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        alu_result = '0;
        alu_cout   = 1'b0;
        applyStimulus(ALU_XOR, 2'd1, 16'hAAAA, 2'd2, 16'h5555, 1'b0, 16'h0, 1'b1, 1'b1, 2'd3, 1'b1);

        // Reset held with in_valid asserted
        tick();
        tick();
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_in1", alu_input1, 0);
        checkOutput("rst_in2", alu_input2, 0);
        checkOutput("rst_cin", alu_cin, 0);
        checkOutput("rst_op", alu_op, 0);
        checkOutput("rst_carry", carry_flag, 0);
        reset = 1'b0;
        checkOutput("rst_ready", in_ready, 1);

        // I1: ADD r1 <- 3 + 4, first accept after reset
        applyStimulus(ALU_ADD, 2'd0, 16'h0003, 2'd3, 16'h0004, 1'b0, 16'h0, 1'b0, 1'b0, 2'd1, 1'b1);
        tick();
        checkOutput("i1_valid", out_valid, 1);
        checkOutput("i1_in1", alu_input1, 16'h0003);
        checkOutput("i1_in2", alu_input2, 16'h0004);
        checkOutput("i1_op", alu_op, ALU_ADD);
        checkOutput("i1_rd", out_rd_addr, 1);

        // I2 reads r1 while I1 retires -> EX forward of 0x0007
        alu_result = 16'h0007;
        applyStimulus(ALU_SUB, 2'd1, 16'hDEAD, 2'd0, 16'h0010, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("ex_fwd_in1", alu_input1, 16'h0007);
        checkOutput("ex_fwd_in2", alu_input2, 16'h0010);

        // I3 reads r2 from writeback; held I2 does not write
        wb_valid = 1'b1;
        wb_addr  = 2'd2;
        wb_data  = 16'h1234;
        alu_result = 16'h0002;
        applyStimulus(ALU_OR, 2'd3, 16'h0101, 2'd2, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0, 2'd2, 1'b1);
        tick();
        checkOutput("wb_fwd_in2", alu_input2, 16'h1234);
        checkOutput("wb_fwd_in1", alu_input1, 16'h0101);

        // I4 reads r2: retiring I3 (writes r2) beats stale writeback entry
        alu_result = 16'h5555;
        applyStimulus(ALU_AND, 2'd0, 16'h00F0, 2'd2, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("prio_in2", alu_input2, 16'h5555);

        // I5: LHI immediate lands on input2
        wb_valid = 1'b0;
        applyStimulus(ALU_LHI, 2'd1, 16'h0000, 2'd2, 16'hBEEF, 1'b1, 16'h00AB, 1'b0, 1'b0, 2'd3, 1'b0);
        tick();
        checkOutput("imm_in2", alu_input2, 16'h00AB);
        checkOutput("imm_op", alu_op, ALU_LHI);

        // I6: ADD 0xFFFF + 0x0001 setting carry
        applyStimulus(ALU_ADD, 2'd0, 16'hFFFF, 2'd3, 16'h0001, 1'b0, 16'h0, 1'b0, 1'b1, 2'd0, 1'b0);
        tick();
        checkOutput("add_cin", alu_cin, 0);
        checkOutput("add_setc", out_set_carry, 1);

        // I7: ADC accepted while I6 retires with Cout=1
        alu_result = 16'h0000;
        alu_cout   = 1'b1;
        applyStimulus(ALU_ADC, 2'd0, 16'h0100, 2'd3, 16'h0200, 1'b0, 16'h0, 1'b1, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("adc_cin", alu_cin, 1);
        checkOutput("adc_carry", carry_flag, 1);

        // Backpressure: I8 waits while I7 is held for 3 cycles
        alu_cout  = 1'b0;
        out_ready = 1'b0;
        applyStimulus(ALU_SUB, 2'd0, 16'h1111, 2'd3, 16'h2222, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        checkOutput("bp_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_valid", out_valid, 1);
            checkOutput("bp_in1", alu_input1, 16'h0100);
            checkOutput("bp_in2", alu_input2, 16'h0200);
            checkOutput("bp_op", alu_op, ALU_ADC);
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_ready_rel", in_ready, 1);
        tick();
        checkOutput("bp_load_in1", alu_input1, 16'h1111);
        checkOutput("bp_load_op", alu_op, ALU_SUB);
        checkOutput("bp_carry_kept", carry_flag, 1);
        in_valid = 1'b0;
        tick();
        checkOutput("bp_no_dup", out_valid, 0);

        // Flush: held carry-setting ADD discarded, incoming not captured
        applyStimulus(ALU_ADD, 2'd0, 16'h0005, 2'd3, 16'h0006, 1'b0, 16'h0, 1'b0, 1'b1, 2'd0, 1'b0);
        tick();
        checkOutput("fl_held", out_valid, 1);
        applyStimulus(ALU_XOR, 2'd0, 16'h7777, 2'd3, 16'h8888, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        alu_cout = 1'b0;
        flush    = 1'b1;
        #1;
        checkOutput("fl_ready", in_ready, 1);
        tick();
        checkOutput("fl_valid", out_valid, 0);
        checkOutput("fl_carry", carry_flag, 1);
        checkOutput("fl_in1", alu_input1, 16'h0005);
        flush    = 1'b0;
        in_valid = 1'b0;

        // Reset mid-operation clears held instruction and carry at once
        applyStimulus(ALU_ADD, 2'd0, 16'h0009, 2'd3, 16'h0009, 1'b0, 16'h0, 1'b0, 1'b0, 2'd0, 1'b0);
        tick();
        checkOutput("mid_held", out_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_valid", out_valid, 0);
        checkOutput("mid_carry", carry_flag, 0);
        checkOutput("mid_in1", alu_input1, 0);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Registered operand-delivery stage directly upstream of the 16-bit ALU in the TSC-ISA datapath.
- Accepts one decoded instruction per handshake and resolves RAW hazards by forwarding.
- Selects register/immediate operands and supplies the carry-in from an architectural carry flag.
- Presents stable input1/input2/Cin/OP to the ALU for exactly one instruction; the ALU result and Cout return to this block for forwarding and carry update.

Parameters:
- DATA_W, 16, operand/result width
- RADDR_W, 2, register address width (4 GPRs, none hardwired to zero)
- OP_W, 4, ALU opcode width (ALU_* encodings)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage can accept this cycle
- in_op  in  OP_W  ALU opcode
- in_rs_addr, in_rt_addr  in  RADDR_W  source register addresses
- in_rs_data, in_rt_data  in  DATA_W  register-file read data
- in_imm  in  DATA_W  sign/zero-extended immediate (extension done by decoder)
- in_use_imm  in  1  input2 = in_imm instead of rt
- in_use_carry  in  1  Cin = carry flag (ADC/SBC); else Cin = 0
- in_set_carry  in  1  instruction updates carry flag from Cout
- in_rd_addr  in  RADDR_W  destination register
- in_wr_en  in  1  instruction writes rd
- flush  in  1  discard held and incoming instruction
- wb_valid, wb_addr, wb_data  in  1/RADDR_W/DATA_W  writeback-stage forward source
- alu_result  in  DATA_W  ALU result for held instruction
- alu_cout  in  1  ALU carry-out for held instruction
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream consumes held instruction
- alu_input1, alu_input2  out  DATA_W  ALU operands (registered)
- alu_cin  out  1  ALU carry-in (registered)
- alu_op  out  OP_W  ALU opcode (registered)
- out_rd_addr, out_wr_en, out_set_carry  out  RADDR_W/1/1  carried sideband
- carry_flag  out  1  architectural carry flag

Behaviour:
- Reset (async, active-high): all outputs and registers 0; carry_flag = 0; out_valid = 0.
- in_ready = ~out_valid | out_ready (combinational). Accept = in_valid & in_ready & ~flush.
- Retire = out_valid & out_ready & ~flush.
- Latency: 1 cycle. An accepted instruction appears on the ALU inputs the next cycle. Throughput is 1/cycle while out_ready = 1.
- Register updates:
  - On accept: register all outputs; out_valid <= 1.
  - Else on retire: out_valid <= 0.
  - Else: hold all outputs stable.
- Forwarding for the rs and rt operands, evaluated at accept, priority high to low:
  1. Held instruction retiring this cycle with out_wr_en and out_rd_addr == src: use alu_result.
  2. wb_valid & wb_addr == src: use wb_data.
  3. Otherwise: register-file data.
  - When in_ready = 1, the held instruction is either absent or retiring, so no other hazard case exists.
- Operand select: alu_input1 = fwd(rs); alu_input2 = in_use_imm ? in_imm : fwd(rt). LHI is encoded with in_use_imm = 1 so the immediate lands on input2.
- Carry:
  - On retire with out_set_carry: carry_flag <= alu_cout.
  - alu_cin captured at accept = in_use_carry & (retiring held with out_set_carry ? alu_cout : carry_flag).
- Flush:
  - Next cycle out_valid = 0. No accept occurs and no carry update happens, even if out_ready = 1.
  - in_ready still reports the formula; upstream discards its own instruction on flush.
- Reset mid-operation: the held instruction is lost and carry_flag is cleared immediately.
- Back-to-back same destination: the retiring held result wins over a stale wb entry for the same address.

Decomposition:
- Shared package/header: the existing ALU_* opcode defines, plus new FWD_SRC_REG/FWD_SRC_EX/FWD_SRC_WB encodings.
- One sub-module, operand_forward_mux (address compare plus 3-way priority select), instantiated twice for rs and rt.

Test Plan:
- Reset with in_valid = 1 held through: out_valid = 0, alu_* = 0, carry_flag = 0. First accept after deassert appears on the next cycle.
- EX forward: I1 ADD rd=1, rs=0x0003, rt=0x0004, retiring while I2 reads rs=1 and regfile rs_data = 0xDEAD -> I2 alu_input1 = 0x0007.
- WB forward and priority:
  - wb_valid, wb_addr = 2, wb_data = 0x1234, I reads rt = 2 -> alu_input2 = 0x1234.
  - Same case plus a retiring held writer to r2 with alu_result = 0x5555 -> alu_input2 = 0x5555.
- Carry chain: ADD with set_carry, 0xFFFF+0x0001 (alu_cout = 1), retiring while ADC (use_carry) accepted -> ADC alu_cin = 1; carry_flag = 1 next cycle.
- Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready = 0; outputs hold bit-identical. out_ready = 1 -> next instruction loads the following cycle, with no loss or duplication.
- Flush: held ADD with set_carry, out_ready = 1, flush = 1 -> out_valid = 0 next cycle, carry_flag unchanged, incoming instruction not captured.
